// File: rtl/poly_voice_mixer.sv
// Polyphonic voice mixer. Each voice has a gated linear attack/release envelope.
// A single time-shared MAC sums one voice per clock, then the sum is saturated to SAMPLE_W.
//
// state  | meaning
// IDLE   | waiting for sample_tick; on a tick, snapshot samples and step envelopes
// ACCUM  | one multiply-accumulate per cycle, voices 0..NUM_VOICES-1
// OUTPUT | scale, saturate and register sig_out; pulse sig_valid
module poly_voice_mixer #(
   parameter int NUM_VOICES   = 4,
   parameter int SAMPLE_W     = 16,
   parameter int ENV_W        = 8,
   parameter int ATTACK_STEP  = 64,
   parameter int RELEASE_STEP = 32
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             sample_tick,
   input  logic [NUM_VOICES-1:0]            gate,
   input  logic [NUM_VOICES*SAMPLE_W-1:0]   voice_in,
   output logic signed [SAMPLE_W-1:0]       sig_out,
   output logic                             sig_valid,
   output logic [NUM_VOICES-1:0]            active,
   output logic                             overrun
);

   localparam int IDX_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
   localparam int ACC_W  = SAMPLE_W + ENV_W + $clog2(NUM_VOICES) + 1;
   localparam int PROD_W = SAMPLE_W + ENV_W + 1;

   localparam logic [ENV_W:0]   ENV_MAX_W = {1'b0, {ENV_W{1'b1}}};
   localparam logic [ENV_W-1:0] ENV_MAX   = {ENV_W{1'b1}};
   localparam logic [ENV_W:0]   ATK_W     = (ENV_W+1)'(ATTACK_STEP);
   localparam logic [ENV_W:0]   REL_W     = (ENV_W+1)'(RELEASE_STEP);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_VOICES - 1);

   localparam logic signed [ACC_W-1:0] SAT_MAX =
      {{(ACC_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN =
      {{(ACC_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;

   state_t                      state_q, state_d;
   logic [IDX_W-1:0]            idx_q;
   logic [ENV_W-1:0]            env_q [NUM_VOICES];
   logic [ENV_W-1:0]            env_d [NUM_VOICES];
   logic [ENV_W:0]              env_up [NUM_VOICES];
   logic signed [SAMPLE_W-1:0]  samp_q [NUM_VOICES];
   logic signed [ACC_W-1:0]     acc_q;
   logic signed [PROD_W-1:0]    samp_ext, env_ext, prod;
   logic signed [ACC_W-1:0]     shifted, sat;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (sample_tick) state_d = ACCUM;
         ACCUM:   if (idx_q == IDX_LAST) state_d = OUTPUT;
         OUTPUT:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Envelope steps are computed one bit wider so the clamp sees the true sum.
   always_comb begin
      for (int i = 0; i < NUM_VOICES; i++) begin
         env_up[i] = {1'b0, env_q[i]} + ATK_W;
         if (gate[i])
            env_d[i] = (env_up[i] > ENV_MAX_W) ? ENV_MAX : env_up[i][ENV_W-1:0];
         else
            env_d[i] = ({1'b0, env_q[i]} < REL_W) ? '0 : env_q[i] - REL_W[ENV_W-1:0];
      end
   end

   always_comb begin
      samp_ext = PROD_W'(samp_q[idx_q]);
      env_ext  = PROD_W'({1'b0, env_q[idx_q]});
      prod     = samp_ext * env_ext;
      shifted  = acc_q >>> ENV_W;
      if (shifted > SAT_MAX)      sat = SAT_MAX;
      else if (shifted < SAT_MIN) sat = SAT_MIN;
      else                        sat = shifted;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q     <= '0;
         acc_q     <= '0;
         sig_out   <= '0;
         sig_valid <= 1'b0;
         active    <= '0;
         overrun   <= 1'b0;
         for (int i = 0; i < NUM_VOICES; i++) begin
            env_q[i]  <= '0;
            samp_q[i] <= '0;
         end
      end else begin
         sig_valid <= 1'b0;
         if (sample_tick && (state_q != IDLE)) overrun <= 1'b1;
         case (state_q)
            IDLE: begin
               if (sample_tick) begin
                  acc_q <= '0;
                  idx_q <= '0;
                  for (int i = 0; i < NUM_VOICES; i++) begin
                     samp_q[i] <= voice_in[i*SAMPLE_W +: SAMPLE_W];
                     env_q[i]  <= env_d[i];
                     active[i] <= (env_d[i] != '0);
                  end
               end
            end
            ACCUM: begin
               acc_q <= acc_q + ACC_W'(prod);
               idx_q <= idx_q + 1'b1;
            end
            OUTPUT: begin
               sig_out   <= sat[SAMPLE_W-1:0];
               sig_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
